// File: rtl/npc_pkg.sv
// Shared types and default vectors for the next-PC unit.
package npc_pkg;

   typedef enum logic [2:0] {
      NPC_ADD4  = 3'd0,
      NPC_BR    = 3'd1,
      NPC_J     = 3'd2,
      NPC_JR    = 3'd3,
      NPC_JAL   = 3'd4,
      NPC_JALR  = 3'd5,
      NPC_JR_RA = 3'd6,
      NPC_ERET  = 3'd7
   } npc_op_t;

   localparam logic [31:0] NPC_RESET_PC = 32'h0000_3000;
   localparam logic [31:0] NPC_EXC_PC   = 32'h0000_4180;

endpackage

// File: rtl/next_pc_unit_if.sv
// ID-stage control/operand bundle into the next-PC unit and its fetch/RAS outputs.
interface next_pc_unit_if
   import npc_pkg::*;
#(
   parameter int XLEN = 32
);
   logic            stall_i;
   npc_op_t         npc_op_i;
   logic            br_taken_i;
   logic [XLEN-1:0] pc4_i;
   logic [15:0]     imm16_i;
   logic [25:0]     imm26_i;
   logic [XLEN-1:0] rs_val_i;
   logic [XLEN-1:0] epc_i;
   logic            exc_i;
   logic [XLEN-1:0] pc_o;
   logic [XLEN-1:0] ras_top_o;
   logic            ras_valid_o;
   logic            ras_miss_o;

   modport master (
      output stall_i, npc_op_i, br_taken_i, pc4_i, imm16_i, imm26_i, rs_val_i, epc_i, exc_i,
      input  pc_o, ras_top_o, ras_valid_o, ras_miss_o
   );

   modport slave (
      input  stall_i, npc_op_i, br_taken_i, pc4_i, imm16_i, imm26_i, rs_val_i, epc_i, exc_i,
      output pc_o, ras_top_o, ras_valid_o, ras_miss_o
   );
endinterface

// File: rtl/npc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module npc_ras
   import npc_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic [XLEN-1:0] data_i,
   output logic [XLEN-1:0] top_o,
   output logic            valid_o
);
   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;

   logic [XLEN-1:0] stack_q [RAS_DEPTH];
   logic [XLEN-1:0] stack_d [RAS_DEPTH];
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   top_idx;

   // ptr_q names the next free slot, so the top lives one below it.
   assign top_idx = ptr_q - PW'(1);
   assign valid_o = (cnt_q != '0);
   assign top_o   = valid_o ? stack_q[top_idx] : '0;

   always_comb begin
      stack_d = stack_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      if (push_i) begin
         stack_d[ptr_q] = data_i;
         ptr_d          = ptr_q + PW'(1);
         if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + CW'(1);
      end else if (pop_i && valid_o) begin
         ptr_d = top_idx;
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RAS_DEPTH; i++) stack_q[i] <= '0;
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         stack_q <= stack_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: rtl/next_pc_unit.sv
// Next fetch PC selection with exception/stall priority and a return-address stack.
module next_pc_unit
   import npc_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter int              RAS_DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC  = XLEN'(NPC_RESET_PC),
   parameter logic [XLEN-1:0] EXC_PC    = XLEN'(NPC_EXC_PC)
) (
   input  logic           clk,
   input  logic           rst_n,
   next_pc_unit_if.slave  bus
);
   logic [XLEN-1:0] pc_q, pc_d;
   logic            miss_q, miss_d;
   logic            push, pop;
   logic [XLEN-1:0] push_data;
   logic [XLEN-1:0] br_target;
   logic [XLEN-1:0] j_target;
   logic [XLEN-1:0] ras_top;
   logic            ras_valid;

   assign br_target = bus.pc4_i + {{(XLEN-18){bus.imm16_i[15]}}, bus.imm16_i, 2'b00};
   assign j_target  = {bus.pc4_i[XLEN-1:28], bus.imm26_i, 2'b00};
   // Return lands past the delay slot, hence PC+4 of the ID instruction plus 4.
   assign push_data = bus.pc4_i + XLEN'(4);

   always_comb begin
      pc_d   = pc_q;
      push   = 1'b0;
      pop    = 1'b0;
      miss_d = 1'b0;
      if (bus.exc_i) begin
         pc_d = EXC_PC;
      end else if (!bus.stall_i) begin
         case (bus.npc_op_i)
            NPC_ADD4:  pc_d = pc_q + XLEN'(4);
            NPC_BR:    pc_d = bus.br_taken_i ? br_target : pc_q + XLEN'(4);
            NPC_J:     pc_d = j_target;
            NPC_JAL: begin
               pc_d = j_target;
               push = 1'b1;
            end
            NPC_JR:    pc_d = bus.rs_val_i;
            NPC_JALR: begin
               pc_d = bus.rs_val_i;
               push = 1'b1;
            end
            NPC_JR_RA: begin
               pc_d   = bus.rs_val_i;
               pop    = 1'b1;
               miss_d = !ras_valid || (bus.rs_val_i != ras_top);
            end
            NPC_ERET:  pc_d = bus.epc_i;
            default:   pc_d = pc_q + XLEN'(4);
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q   <= RESET_PC;
         miss_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         miss_q <= miss_d;
      end
   end

   npc_ras #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (push_data),
      .top_o   (ras_top),
      .valid_o (ras_valid)
   );

   assign bus.pc_o        = pc_q;
   assign bus.ras_top_o   = ras_top;
   assign bus.ras_valid_o = ras_valid;
   assign bus.ras_miss_o  = miss_q;
endmodule

// File: tb/tb_next_pc_unit.sv
// Directed plus randomized checks of next_pc_unit against a queue-based reference model.
module tb_next_pc_unit;
   import npc_pkg::*;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   logic clk;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   next_pc_unit_if #(.XLEN(XLEN)) bus ();

   next_pc_unit #(.XLEN(XLEN), .RAS_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] m_pc;
   logic [31:0] m_ras[$];
   logic        m_miss;

   function automatic logic [31:0] m_top();
      return (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".pc"},    64'(bus.pc_o),        64'(m_pc));
      chk({tag, ".top"},   64'(bus.ras_top_o),   64'(m_top()));
      chk({tag, ".valid"}, 64'(bus.ras_valid_o), 64'(m_ras.size() > 0));
      chk({tag, ".miss"},  64'(bus.ras_miss_o),  64'(m_miss));
   endtask

   task automatic drive(input npc_op_t op, input logic taken, input logic [31:0] pc4,
                        input logic [15:0] imm16, input logic [25:0] imm26,
                        input logic [31:0] rs, input logic [31:0] epc,
                        input logic stall, input logic exc);
      bus.npc_op_i   = op;
      bus.br_taken_i = taken;
      bus.pc4_i      = pc4;
      bus.imm16_i    = imm16;
      bus.imm26_i    = imm26;
      bus.rs_val_i   = rs;
      bus.epc_i      = epc;
      bus.stall_i    = stall;
      bus.exc_i      = exc;
   endtask

   // Reference: apply one commit to the model from the currently driven inputs.
   task automatic model_step();
      logic [31:0] sext;
      m_miss = 1'b0;
      if (bus.exc_i) begin
         m_pc = 32'h0000_4180;
      end else if (!bus.stall_i) begin
         sext = 32'($signed(bus.imm16_i)) * 4;
         case (bus.npc_op_i)
            NPC_ADD4:  m_pc = m_pc + 4;
            NPC_BR:    m_pc = bus.br_taken_i ? bus.pc4_i + sext : m_pc + 4;
            NPC_J:     m_pc = (bus.pc4_i & 32'hF000_0000) | (32'(bus.imm26_i) * 4);
            NPC_JAL: begin
               m_pc = (bus.pc4_i & 32'hF000_0000) | (32'(bus.imm26_i) * 4);
               m_ras.push_back(bus.pc4_i + 4);
               if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
            NPC_JR:    m_pc = bus.rs_val_i;
            NPC_JALR: begin
               m_pc = bus.rs_val_i;
               m_ras.push_back(bus.pc4_i + 4);
               if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
            NPC_JR_RA: begin
               m_miss = (m_ras.size() == 0) || (bus.rs_val_i != m_top());
               m_pc   = bus.rs_val_i;
               if (m_ras.size() > 0) void'(m_ras.pop_back());
            end
            default:   m_pc = bus.epc_i;
         endcase
      end
   endtask

   task automatic step(input string tag);
      model_step();
      @(posedge clk);
      #1;
      chk_all(tag);
   endtask

   task automatic model_reset();
      m_pc   = 32'h0000_3000;
      m_ras.delete();
      m_miss = 1'b0;
   endtask

   // Asserts reset between edges and checks the outputs respond without a clock.
   task automatic mid_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk_all({tag, ".async"});
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_all({tag, ".rel"});
   endtask

   initial begin
      logic [31:0] rs;
      npc_op_t     op;
      rst_n = 1'b0;
      drive(NPC_ADD4, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_all("reset");
      chk("reset_pc", 64'(bus.pc_o), 64'h3000);

      repeat (3) step("add4");
      chk("add4_x3", 64'(bus.pc_o), 64'h300C);

      drive(NPC_BR, 1'b1, 32'h3008, 16'hFFFE, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      step("br_taken");
      chk("br_back", 64'(bus.pc_o), 64'h3000);
      drive(NPC_BR, 1'b0, 32'h3008, 16'hFFFE, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      step("br_not");
      chk("br_fall", 64'(bus.pc_o), 64'h3004);

      drive(NPC_JAL, 1'b0, 32'h3010, 16'h0, 26'h0C00, 32'h0, 32'h0, 1'b0, 1'b0);
      step("jal");
      chk("jal_top", 64'(bus.ras_top_o), 64'h3014);
      drive(NPC_JR_RA, 1'b0, 32'h0, 16'h0, 26'h0, 32'h3014, 32'h0, 1'b0, 1'b0);
      step("jr_ra");
      chk("jr_ra_pc", 64'(bus.pc_o), 64'h3014);
      chk("jr_ra_hit", 64'(bus.ras_miss_o), 64'h0);
      chk("jr_ra_empty", 64'(bus.ras_valid_o), 64'h0);

      for (int i = 1; i <= 5; i++) begin
         drive(NPC_JAL, 1'b0, 32'(i) << 8, 16'h0, 26'(i * 16), 32'h0, 32'h0, 1'b0, 1'b0);
         step("jal5");
      end
      chk("ras_full_top", 64'(bus.ras_top_o), 64'h504);
      for (int i = 5; i >= 2; i--) begin
         drive(NPC_JR_RA, 1'b0, 32'h0, 16'h0, 26'h0, (32'(i) << 8) + 4, 32'h0, 1'b0, 1'b0);
         step("pop_hit");
         chk("pop_hit_miss", 64'(bus.ras_miss_o), 64'h0);
      end
      drive(NPC_JR_RA, 1'b0, 32'h0, 16'h0, 26'h0, 32'h104, 32'h0, 1'b0, 1'b0);
      step("pop_empty");
      chk("pop_empty_miss", 64'(bus.ras_miss_o), 64'h1);
      drive(NPC_ADD4, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      step("miss_clear");
      chk("miss_pulse", 64'(bus.ras_miss_o), 64'h0);

      drive(NPC_JAL, 1'b0, 32'h3100, 16'h0, 26'h0C40, 32'h0, 32'h0, 1'b0, 1'b0);
      step("pre_stall");
      drive(NPC_JAL, 1'b0, 32'h3200, 16'h0, 26'h0C80, 32'h0, 32'h0, 1'b1, 1'b0);
      step("stall_jal");
      chk("stall_pc", 64'(bus.pc_o), 64'h3100);
      chk("stall_top", 64'(bus.ras_top_o), 64'h3104);
      drive(NPC_J, 1'b0, 32'h3200, 16'h0, 26'h0C80, 32'h0, 32'h0, 1'b0, 1'b1);
      step("exc_j");
      chk("exc_pc", 64'(bus.pc_o), 64'h4180);
      chk("exc_top", 64'(bus.ras_top_o), 64'h3104);
      drive(NPC_JAL, 1'b0, 32'h3300, 16'h0, 26'h0CC0, 32'h0, 32'h0, 1'b0, 1'b1);
      step("exc_jal");

      drive(NPC_JAL, 1'b0, 32'h3400, 16'h0, 26'h0D00, 32'h0, 32'h0, 1'b0, 1'b0);
      step("pre_rst");
      drive(NPC_JALR, 1'b0, 32'h3500, 16'h0, 26'h0, 32'h7777_0000, 32'h0, 1'b0, 1'b0);
      mid_reset("mid_rst");
      chk("mid_rst_pc", 64'(bus.pc_o), 64'h3000);
      chk("mid_rst_valid", 64'(bus.ras_valid_o), 64'h0);
      drive(NPC_ADD4, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      step("post_rst");

      for (int i = 0; i < 400; i++) begin
         op = npc_op_t'($urandom_range(0, 7));
         rs = $urandom();
         if (op == NPC_JR_RA && $urandom_range(0, 3) != 0) rs = m_top();
         drive(op, 1'($urandom()), $urandom() & 32'hFFFF_FFFC, 16'($urandom()),
               26'($urandom()), rs, $urandom(),
               $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
         if (i == 200) mid_reset("rnd_rst");
         else step("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
